// File: rtl/totlen_pkg.sv
// Shared types and constants for the totlen length tagger.
package totlen_pkg;

  localparam int LEN_W  = 16;
  localparam int DATA_W = 8;

  // One buffered payload byte plus its end-of-packet marker.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  // Next byte count: wraps modulo 2^LEN_W, or sticks at all-ones when sat is set.
  function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] cnt,
                                               input logic             sat);
    if (sat && (cnt == {LEN_W{1'b1}})) begin
      return cnt;
    end
    return cnt + LEN_W'(1);
  endfunction

endpackage

// File: rtl/totlen_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty and synchronous reset.
// The head word is visible on pop_data as soon as the FIFO is non-empty and
// reads as zero while empty. Push on full and pop on empty are ignored.
module totlen_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because empty masks the read port.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/totlen.sv
// totlen: buffers an AXI-Stream byte packet and emits its total length on a
// separate 16-bit length stream when the last byte is accepted.
// Build option: define TOTLEN_SATURATE_EN to make the byte counter saturate at
// 0xFFFF instead of wrapping modulo 65536.
module totlen
  import totlen_pkg::*;
#(
  parameter int DATA_DEPTH = 2048,
  parameter int LEN_DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic              length_tvalid,
  input  logic              length_tready,
  output logic [LEN_W-1:0]  length_tdata
);

`ifdef TOTLEN_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  // Handshake rule for all three streams: a transfer happens on a rising edge
  // where valid && ready; valid never looks at ready, and payload is held
  // stable while valid && !ready.

  logic [LEN_W-1:0] byte_cnt;
  logic [LEN_W-1:0] cnt_inc;
  logic             accept;
  logic             data_full;
  logic             data_empty;
  logic             len_full;
  logic             len_empty;
  beat_t            in_beat;
  beat_t            out_beat;

  // Stall input whenever either FIFO is full so nothing is ever dropped.
  assign s_tready = !rst && !data_full && !len_full;
  assign accept   = s_tvalid && s_tready;
  assign cnt_inc  = len_inc(byte_cnt, SAT_EN);
  assign in_beat  = {s_tlast, s_tdata};

  assign m_tvalid      = !data_empty;
  assign m_tdata       = out_beat.data;
  assign m_tlast       = out_beat.last;
  assign length_tvalid = !len_empty;

  // Running byte count of the packet in flight; restarts after each tlast beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
    end else if (accept) begin
      byte_cnt <= s_tlast ? '0 : cnt_inc;
    end
  end

  totlen_fifo #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (DATA_DEPTH)
  ) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (in_beat),
    .pop       (m_tready),
    .pop_data  (out_beat),
    .full      (data_full),
    .empty     (data_empty)
  );

  totlen_fifo #(
    .WIDTH (LEN_W),
    .DEPTH (LEN_DEPTH)
  ) u_len_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept && s_tlast),
    .push_data (cnt_inc),
    .pop       (length_tready),
    .pop_data  (length_tdata),
    .full      (len_full),
    .empty     (len_empty)
  );

endmodule

// File: tb/tb_totlen.sv
// Bench for totlen: table-driven packets, hand-written corner sequences,
// randomized traffic against a packet-level reference model.
module tb_totlen;
  import totlen_pkg::*;

  localparam int DATA_DEPTH = 2048;
  localparam int LEN_DEPTH  = 16;
  localparam int BUDGET     = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  s_tdata;
  logic        s_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [7:0]  m_tdata;
  logic        m_tlast;
  logic        length_tvalid;
  logic        length_tready;
  logic [15:0] length_tdata;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  totlen #(
    .DATA_DEPTH (DATA_DEPTH),
    .LEN_DEPTH  (LEN_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .s_tdata       (s_tdata),
    .s_tlast       (s_tlast),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .m_tdata       (m_tdata),
    .m_tlast       (m_tlast),
    .length_tvalid (length_tvalid),
    .length_tready (length_tready),
    .length_tdata  (length_tdata)
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [8:0]  exp_q[$];
  logic [15:0] exp_len_q[$];
  int          pkt_bytes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reported length for a packet of n bytes, straight from the counting rule.
  function automatic logic [15:0] model_len(input int n);
`ifdef TOTLEN_SATURATE_EN
    return (n >= 65535) ? 16'hFFFF : 16'(n);
`else
    return 16'(n % 65536);
`endif
  endfunction

  // Output monitor: pops the model on every handshake and checks hold-stability.
  logic       prev_m_stall = 1'b0;
  logic       prev_l_stall = 1'b0;
  logic [8:0] prev_m       = '0;
  logic [15:0] prev_l      = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_m_stall = 1'b0;
      prev_l_stall = 1'b0;
    end else begin
      if (prev_m_stall) begin
        check("m_hold_valid", 32'(m_tvalid), 32'd1);
        check("m_hold_data", 32'({m_tlast, m_tdata}), 32'(prev_m));
      end
      if (prev_l_stall) begin
        check("len_hold_valid", 32'(length_tvalid), 32'd1);
        check("len_hold_data", 32'(length_tdata), 32'(prev_l));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) check("m_unexpected_beat", 32'(m_tvalid), 32'd0);
        else check("m_beat", 32'({m_tlast, m_tdata}), 32'(exp_q.pop_front()));
      end
      if (length_tvalid && length_tready) begin
        if (exp_len_q.size() == 0) check("len_unexpected", 32'(length_tvalid), 32'd0);
        else check("len_value", 32'(length_tdata), 32'(exp_len_q.pop_front()));
      end
      prev_m_stall = m_tvalid && !m_tready;
      prev_l_stall = length_tvalid && !length_tready;
      prev_m       = {m_tlast, m_tdata};
      prev_l       = length_tdata;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send_beat(input logic [7:0] d, input logic last);
    int waited = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    @(negedge clk);
    while (!s_tready && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    if (!s_tready) begin
      check("s_tready_timeout", 32'(s_tready), 32'd1);
      s_tvalid = 1'b0;
      return;
    end
    exp_q.push_back({last, d});
    if (last) begin
      exp_len_q.push_back(model_len(pkt_bytes + 1));
      pkt_bytes = 0;
    end else begin
      pkt_bytes++;
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    exp_len_q.delete();
    pkt_bytes = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_len_valid();
    int waited = 0;
    @(negedge clk);
    while (!length_tvalid && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    check("length_wait", 32'(length_tvalid), 32'd1);
  endtask

  // Opens both consumers until the model is empty, then closes them.
  task automatic drain_all();
    int waited = 0;
    @(posedge clk); #1;
    m_tready      = 1'b1;
    length_tready = 1'b1;
    @(negedge clk);
    while ((exp_q.size() + exp_len_q.size()) != 0 && waited < 4 * BUDGET) begin
      @(negedge clk);
      waited++;
    end
    check("drain", 32'(exp_q.size() + exp_len_q.size()), 32'd0);
    @(posedge clk); #1;
    m_tready      = 1'b0;
    length_tready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          nbytes;
    int          first;
    int          gap;
    logic [15:0] exp_len;
  } vec_t;

  vec_t vecs[5];
  logic rand_done;

  initial begin
    vecs[0] = '{nbytes: 4, first: 1,   gap: 3, exp_len: 16'd4};
    vecs[1] = '{nbytes: 5, first: 5,   gap: 0, exp_len: 16'd5};
    vecs[2] = '{nbytes: 6, first: 10,  gap: 0, exp_len: 16'd6};
    vecs[3] = '{nbytes: 3, first: 200, gap: 1, exp_len: 16'd3};
    vecs[4] = '{nbytes: 1, first: 77,  gap: 2, exp_len: 16'd1};

    rst = 1'b1;
    s_tvalid = 1'b0;
    s_tdata = '0;
    s_tlast = 1'b0;
    m_tready = 1'b0;
    length_tready = 1'b0;
    rand_done = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_len_tvalid", 32'(length_tvalid), 32'd0);
    check("rst_m_tdata", 32'(m_tdata), 32'd0);
    check("rst_m_tlast", 32'(m_tlast), 32'd0);
    check("rst_len_tdata", 32'(length_tdata), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_tready", 32'(s_tready), 32'd1);
    @(posedge clk); #1;

    // Table-driven packets: consumer waits for the length, then drains payload
    for (int v = 0; v < 5; v++) begin
      for (int b = 0; b < vecs[v].nbytes; b++) begin
        send_beat(8'(vecs[v].first + b), b == vecs[v].nbytes - 1);
        repeat (vecs[v].gap) begin @(posedge clk); #1; end
      end
      wait_len_valid();
      check("tbl_len", 32'(length_tdata), 32'(vecs[v].exp_len));
      check("tbl_first_byte", 32'(m_tdata), 32'(vecs[v].first));
      drain_all();
    end

    // Length FIFO full: 16 one-byte packets with both consumers stalled
    for (int i = 0; i < LEN_DEPTH; i++) send_beat(8'(i + 32), 1'b1);
    @(negedge clk);
    check("len_full_s_tready", 32'(s_tready), 32'd0);
    check("len_full_len_tvalid", 32'(length_tvalid), 32'd1);
    @(posedge clk); #1 length_tready = 1'b1;
    @(posedge clk); #1 length_tready = 1'b0;
    @(negedge clk);
    check("len_pop_s_tready", 32'(s_tready), 32'd1);
    drain_all();

    // One-byte packet: length appears the cycle after acceptance
    @(negedge clk);
    check("one_byte_pre_len", 32'(length_tvalid), 32'd0);
    @(posedge clk); #1;
    send_beat(8'h5A, 1'b1);
    check("one_byte_len_tvalid", 32'(length_tvalid), 32'd1);
    check("one_byte_len", 32'(length_tdata), 32'd1);
    check("one_byte_m_tvalid", 32'(m_tvalid), 32'd1);
    check("one_byte_m_tdata", 32'(m_tdata), 32'h5A);
    check("one_byte_m_tlast", 32'(m_tlast), 32'd1);
    drain_all();

    // Reset mid-packet discards buffered bytes and the partial count
    send_beat(8'hE1, 1'b0);
    send_beat(8'hE2, 1'b0);
    send_beat(8'hE3, 1'b0);
    do_reset();
    @(negedge clk);
    check("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("midrst_len_tvalid", 32'(length_tvalid), 32'd0);
    check("midrst_s_tready", 32'(s_tready), 32'd1);
    @(posedge clk); #1;
    send_beat(8'hA1, 1'b0);
    send_beat(8'hA2, 1'b1);
    wait_len_valid();
    check("midrst_len", 32'(length_tdata), 32'd2);
    check("midrst_first", 32'(m_tdata), 32'hA1);
    drain_all();

    // Randomized traffic with random consumer back-pressure
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          int n;
          n = $urandom_range(1, 24);
          for (int b = 0; b < n; b++) begin
            send_beat(8'($urandom), b == n - 1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          m_tready      = ($urandom_range(0, 3) != 0);
          length_tready = ($urandom_range(0, 2) == 0);
        end
      end
    join
    drain_all();

    // 65537-byte packet with continuous payload draining
    @(posedge clk); #1 m_tready = 1'b1;
    for (int i = 0; i < 65537; i++) send_beat(8'(i), i == 65536);
    wait_len_valid();
`ifdef TOTLEN_SATURATE_EN
    check("big_len", 32'(length_tdata), 32'd65535);
`else
    check("big_len", 32'(length_tdata), 32'd1);
`endif
    drain_all();

    @(negedge clk);
    check("end_m_tvalid", 32'(m_tvalid), 32'd0);
    check("end_len_tvalid", 32'(length_tvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
